// File: rtl/button_pkg.sv
// Shared types, default timing and helpers for the button event conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHoldUp,
    StHoldDn
  } pair_state_e;

  localparam int unsigned DefDebounceCycles    = 250000;
  localparam int unsigned DefCoincidenceCycles = 500000;
  localparam int unsigned DefRepeatDelay       = 25000000;
  localparam int unsigned DefRepeatPeriod      = 10000000;
  localparam bit          DefActiveLow         = 1'b1;

  // Width of a counter that must hold 0 .. cycles-1 (at least one bit).
  function automatic int unsigned wc_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchroniser, polarity normalisation, debounce and press-edge detect.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter bit          ACTIVE_LOW      = DefActiveLow
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned     CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  // Raw level of a key that is not being pressed.
  localparam logic            Released = ACTIVE_LOW;

  logic            sync1_q, sync2_q;
  logic            pressed;
  logic            level_d, level_q, level_prev_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (pressed != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = pressed;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= Released;
      sync2_q      <= Released;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/button_event_conditioner.sv
// Turns two raw keys into one-cycle Up/Down pulses, pairing near-simultaneous presses.
// Auto-repeat of held keys is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_event_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DefDebounceCycles,
  parameter bit          ACTIVE_LOW         = DefActiveLow,
  parameter int unsigned COINCIDENCE_CYCLES = DefCoincidenceCycles,
  parameter int unsigned REPEAT_DELAY       = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD      = DefRepeatPeriod
) (
  input  logic clock,
  input  logic Reset,
  input  logic KeyUp,
  input  logic KeyDown,
  output logic Up,
  output logic Down,
  output logic UpLevel,
  output logic DownLevel
);

  localparam int unsigned    WcW      = wc_width(COINCIDENCE_CYCLES);
  localparam bit             NoWindow = (COINCIDENCE_CYCLES == 0);
  localparam logic [WcW-1:0] WcLast   = NoWindow ? '0 : WcW'(COINCIDENCE_CYCLES - 1);

  logic           up_level, dn_level, up_press, dn_press;
  pair_state_e    state_d, state_q;
  logic [WcW-1:0] wc_d, wc_q;
  logic           hold_other, hold_expire;
  logic           up_evt, dn_evt, up_rep, dn_rep;
  logic           up_d, up_q, dn_d, dn_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_up (
    .clk_i  (clock),
    .rst_i  (Reset),
    .key_i  (KeyUp),
    .level_o(up_level),
    .press_o(up_press)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_dn (
    .clk_i  (clock),
    .rst_i  (Reset),
    .key_i  (KeyDown),
    .level_o(dn_level),
    .press_o(dn_press)
  );

  assign hold_other  = (state_q == StHoldUp) ? dn_press : up_press;
  assign hold_expire = (wc_q == WcLast);

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= StIdle;
      wc_q    <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wc_d    = '0;
    unique case (state_q)
      StIdle: begin
        if ((up_press != dn_press) && !NoWindow) begin
          state_d = up_press ? StHoldUp : StHoldDn;
        end
      end
      StHoldUp, StHoldDn: begin
        // A repeated press of the held key is ignored; the window keeps running.
        if (hold_other || hold_expire) begin
          state_d = StIdle;
        end else begin
          wc_d = wc_q + WcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    up_evt = 1'b0;
    dn_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (up_press && dn_press) begin
          up_evt = 1'b1;
          dn_evt = 1'b1;
        end else if (NoWindow) begin
          up_evt = up_press;
          dn_evt = dn_press;
        end
      end
      StHoldUp: begin
        if (hold_other || hold_expire) begin
          up_evt = 1'b1;
          dn_evt = hold_other;
        end
      end
      StHoldDn: begin
        if (hold_other || hold_expire) begin
          dn_evt = 1'b1;
          up_evt = hold_other;
        end
      end
      default: ;
    endcase
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned    RcMax   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
  localparam int unsigned    RcW     = $clog2(RcMax + 1);
  localparam logic [RcW-1:0] RcDelay = RcW'(REPEAT_DELAY - 1);
  localparam logic [RcW-1:0] RcPer   = RcW'(REPEAT_PERIOD - 1);

  logic [1:0]          lvl, pulse, fire;
  logic [1:0]          armed_d, armed_q, rep_d, rep_q;
  logic [1:0][RcW-1:0] rc_d, rc_q;

  assign lvl   = {dn_level, up_level};
  assign pulse = {dn_q, up_q};

  // Each visible pulse of a held key restarts its timer; the first wait is the
  // longer delay, later ones the period. An expired timer waits for IDLE.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      armed_d[k] = armed_q[k];
      rep_d[k]   = rep_q[k];
      rc_d[k]    = rc_q[k];
      fire[k]    = 1'b0;
      if (!lvl[k]) begin
        armed_d[k] = 1'b0;
        rep_d[k]   = 1'b0;
        rc_d[k]    = '0;
      end else if (pulse[k]) begin
        armed_d[k] = 1'b1;
        rc_d[k]    = RcW'(1);
      end else if (armed_q[k]) begin
        if (rc_q[k] >= (rep_q[k] ? RcPer : RcDelay)) begin
          if (state_q == StIdle) begin
            fire[k]  = 1'b1;
            rep_d[k] = 1'b1;
          end
        end else begin
          rc_d[k] = rc_q[k] + RcW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      armed_q <= '0;
      rep_q   <= '0;
      rc_q    <= '0;
    end else begin
      armed_q <= armed_d;
      rep_q   <= rep_d;
      rc_q    <= rc_d;
    end
  end

  assign up_rep = fire[0];
  assign dn_rep = fire[1];
`else
  assign up_rep = 1'b0;
  assign dn_rep = 1'b0;
`endif

  assign up_d      = up_evt | up_rep;
  assign dn_d      = dn_evt | dn_rep;
  assign Up        = up_q;
  assign Down      = dn_q;
  assign UpLevel   = up_level;
  assign DownLevel = dn_level;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner with a cycle-level reference model.
module tb_button_event_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned C  = 3;
  localparam int unsigned RD = 6;
  localparam int unsigned RP = 3;

  logic clock   = 1'b0;
  logic Reset   = 1'b1;
  logic KeyUp   = 1'b1;
  logic KeyDown = 1'b1;
  logic Up, Down, UpLevel, DownLevel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  button_event_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .ACTIVE_LOW        (1'b1),
    .COINCIDENCE_CYCLES(C),
    .REPEAT_DELAY      (RD),
    .REPEAT_PERIOD     (RP)
  ) dut (
    .clock    (clock),
    .Reset    (Reset),
    .KeyUp    (KeyUp),
    .KeyDown  (KeyDown),
    .Up       (Up),
    .Down     (Down),
    .UpLevel  (UpLevel),
    .DownLevel(DownLevel)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference model: values it holds after each edge are what the DUT must show.
  bit       m_valid = 1'b0;
  bit [1:0] m_s1, m_s2, m_lvl, m_lvlp, m_out, m_armed, m_rep;
  int       m_run[2];
  int       m_next[2];
  int       m_hold, m_dead, m_t;

  initial forever begin
    bit [1:0] raw, press, evt, p;
    bit       idle;
    @(posedge clock);
    cyc = cyc + 1;
    if (Reset) begin
      m_valid = 1'b1;
      m_s1 = 2'b11; m_s2 = 2'b11;
      m_lvl = '0; m_lvlp = '0; m_out = '0; m_armed = '0; m_rep = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_hold = 0; m_dead = 0; m_t = 0;
    end else begin
      raw   = {KeyDown, KeyUp};
      press = m_lvl & ~m_lvlp;
      idle  = (m_hold == 0);
      evt   = '0;
      if (m_hold == 0) begin
        if (press == 2'b11) evt = 2'b11;
        else if (press != 2'b00) begin
          if (C == 0) evt = press;
          else begin
            m_hold = press[0] ? 1 : 2;
            m_dead = m_t + C;
          end
        end
      end else if ((m_hold == 1 && press[1]) || (m_hold == 2 && press[0])) begin
        evt = 2'b11;
        m_hold = 0;
      end else if (m_t == m_dead) begin
        evt = (m_hold == 1) ? 2'b01 : 2'b10;
        m_hold = 0;
      end
`ifdef BUTTON_AUTOREPEAT_EN
      for (int k = 0; k < 2; k++) begin
        if (!m_lvl[k]) begin
          m_armed[k] = 1'b0;
          m_rep[k]   = 1'b0;
        end else if (m_out[k]) begin
          m_armed[k] = 1'b1;
          m_next[k]  = m_t + (m_rep[k] ? RP : RD);
        end else if (m_armed[k] && idle && (m_t + 1 >= m_next[k])) begin
          evt[k]   = 1'b1;
          m_rep[k] = 1'b1;
        end
      end
`endif
      m_out  = evt;
      p      = ~m_s2;
      m_lvlp = m_lvl;
      for (int k = 0; k < 2; k++) begin
        if (p[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = p[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_t++;
    end
  end

  // Event log for the directed checks.
  int up_n, dn_n, both_n, up_at, ul_rise;
  int dn_at[8];
  bit ul_prev = 1'b0;

  task automatic clr();
    up_n = 0; dn_n = 0; both_n = 0; up_at = -1; ul_rise = -1;
    for (int i = 0; i < 8; i++) dn_at[i] = -1;
  endtask

  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      chk("Up", int'(Up), int'(m_out[0]));
      chk("Down", int'(Down), int'(m_out[1]));
      chk("UpLevel", int'(UpLevel), int'(m_lvl[0]));
      chk("DownLevel", int'(DownLevel), int'(m_lvl[1]));
    end
    if (Up === 1'b1) begin up_n++; up_at = cyc; end
    if (Down === 1'b1) begin
      if (dn_n < 8) dn_at[dn_n] = cyc;
      dn_n++;
    end
    if (Up === 1'b1 && Down === 1'b1) both_n++;
    if (UpLevel === 1'b1 && !ul_prev) ul_rise = cyc;
    ul_prev = (UpLevel === 1'b1);
  end

  initial begin
    int c0, r;
    clr();
    tick(3);
    chk("reset_up", int'(Up), 0);
    chk("reset_down", int'(Down), 0);
    chk("reset_uplevel", int'(UpLevel), 0);
    chk("reset_downlevel", int'(DownLevel), 0);
    Reset = 1'b0;
    tick(3);

    // 1: 3-cycle glitch is rejected
    clr(); KeyUp = 1'b0; tick(3); KeyUp = 1'b1; tick(15);
    chk("glitch_level_rise", ul_rise, -1);
    chk("glitch_up_pulses", up_n, 0);

    // 2: single Up press, released before the window expires
    clr(); c0 = cyc; KeyUp = 1'b0; tick(5); KeyUp = 1'b1; tick(20);
    chk("single_level_latency", ul_rise - c0, 6);
    chk("single_pulse_latency", up_at - c0, 10);
    chk("single_up_pulses", up_n, 1);
    chk("single_down_pulses", dn_n, 0);

    // 3: both keys on the same edge
    clr(); c0 = cyc; KeyUp = 1'b0; KeyDown = 1'b0; tick(5);
    KeyUp = 1'b1; KeyDown = 1'b1; tick(20);
    chk("same_both_cycles", both_n, 1);
    chk("same_up_pulses", up_n, 1);
    chk("same_down_pulses", dn_n, 1);
    chk("same_pulse_latency", up_at - c0, 7);

    // 4: Down then Up two cycles later pairs into one cycle
    clr(); c0 = cyc; KeyDown = 1'b0; tick(2); KeyUp = 1'b0; tick(5);
    KeyUp = 1'b1; KeyDown = 1'b1; tick(20);
    chk("pair_both_cycles", both_n, 1);
    chk("pair_up_pulses", up_n, 1);
    chk("pair_down_pulses", dn_n, 1);
    chk("pair_pulse_latency", up_at - c0, 9);

    // 5: reset while holding an Up press discards it
    clr(); KeyUp = 1'b0; tick(7); Reset = 1'b1; tick(1); r = cyc; Reset = 1'b0;
    chk("rst_hold_up", int'(Up), 0);
    chk("rst_hold_down", int'(Down), 0);
    chk("rst_hold_uplevel", int'(UpLevel), 0);
    chk("rst_hold_downlevel", int'(DownLevel), 0);
    chk("rst_hold_no_pulse", up_n, 0);
    tick(5); KeyUp = 1'b1; tick(20);
    chk("rst_rearm_pulses", up_n, 1);
    chk("rst_rearm_latency", up_at - r, 10);

    // 6: long Down hold
    clr(); c0 = cyc; KeyDown = 1'b0; tick(20); KeyDown = 1'b1; tick(20);
    chk("hold_first_pulse", dn_at[0] - c0, 10);
    chk("hold_up_pulses", up_n, 0);
`ifdef BUTTON_AUTOREPEAT_EN
    chk("hold_down_pulses", dn_n, 5);
    chk("hold_repeat_delay", dn_at[1] - dn_at[0], 6);
    chk("hold_repeat_period", dn_at[2] - dn_at[1], 3);
`else
    chk("hold_down_pulses", dn_n, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
